// File: rtl/ti_pkg.sv
// Shared types and constants for the SN76489-compatible PSG blocks.
package ti_pkg;

    typedef enum logic [2:0] {
        TONE0 = 3'b000,
        VOL0  = 3'b001,
        TONE1 = 3'b010,
        VOL1  = 3'b011,
        TONE2 = 3'b100,
        VOL2  = 3'b101,
        NOISE = 3'b110,
        VOL3  = 3'b111
    } ti_reg_sel_t;

    localparam logic [3:0]  TI_VOL_SILENT   = 4'hF;
    localparam int unsigned TI_BUSY_DEFAULT = 32;

    // Latch bytes replace the low nibble of a tone period, data bytes the upper six bits.
    function automatic logic [9:0] ti_tone_write(input logic [9:0] cur,
                                                 input logic       is_latch,
                                                 input logic [5:0] bits);
        logic [9:0] nxt;
        nxt = cur;
        if (is_latch) nxt[3:0] = bits[3:0];
        else          nxt[9:4] = bits;
        return nxt;
    endfunction

endpackage

// File: rtl/ti_reg_decoder.sv
// CPU write port of the PSG: decodes latch/data bytes into the eight PSG registers
// and stalls wr_ready for BUSY_CYCLES cycles after every accepted byte.
module ti_reg_decoder
    import ti_pkg::*;
#(
    parameter int unsigned BUSY_CYCLES = TI_BUSY_DEFAULT
) (
    input  logic       CLK,
    input  logic       nRST,
    input  logic       wr_valid,
    input  logic [7:0] wr_data,
    output logic       wr_ready,
    output logic [9:0] tone0,
    output logic [9:0] tone1,
    output logic [9:0] tone2,
    output logic [2:0] noise_ctrl,
    output logic       noise_rst,
    output logic [3:0] vol0,
    output logic [3:0] vol1,
    output logic [3:0] vol2,
    output logic [3:0] vol3
);

    localparam int unsigned CNT_W    = (BUSY_CYCLES > 0) ? $clog2(BUSY_CYCLES + 1) : 1;
    localparam bit          HAS_BUSY = (BUSY_CYCLES != 0);
    localparam logic [CNT_W-1:0] CNT_LOAD = HAS_BUSY ? CNT_W'(BUSY_CYCLES - 1) : '0;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  busy_cnt_q, busy_cnt_d;
    logic              ready_q, ready_d;
    ti_reg_sel_t       latched_q, latched_d;
    logic [9:0]        tone0_q, tone0_d, tone1_q, tone1_d, tone2_q, tone2_d;
    logic [3:0]        vol0_q, vol0_d, vol1_q, vol1_d, vol2_q, vol2_d, vol3_q, vol3_d;
    logic [2:0]        noise_q, noise_d;
    logic              noise_rst_q, noise_rst_d;
    logic              accept;
    logic              is_latch;
    ti_reg_sel_t       target;

    assign accept   = wr_valid && (state_q == IDLE);
    assign is_latch = wr_data[7];
    assign target   = is_latch ? ti_reg_sel_t'(wr_data[6:4]) : latched_q;

    // Busy window sequencing.
    always_comb begin
        state_d    = state_q;
        busy_cnt_d = busy_cnt_q;
        unique case (state_q)
            IDLE: if (accept && HAS_BUSY) begin
                state_d    = BUSY;
                busy_cnt_d = CNT_LOAD;
            end
            BUSY: if (busy_cnt_q == '0) state_d = IDLE;
                  else                  busy_cnt_d = busy_cnt_q - CNT_W'(1);
            default: state_d = IDLE;
        endcase
        ready_d = (state_d == IDLE);
    end

    // Register file decode.
    always_comb begin
        latched_d   = latched_q;
        tone0_d     = tone0_q;
        tone1_d     = tone1_q;
        tone2_d     = tone2_q;
        vol0_d      = vol0_q;
        vol1_d      = vol1_q;
        vol2_d      = vol2_q;
        vol3_d      = vol3_q;
        noise_d     = noise_q;
        noise_rst_d = 1'b0;
        if (accept) begin
            if (is_latch) latched_d = target;
            unique case (target)
                TONE0: tone0_d = ti_tone_write(tone0_q, is_latch, wr_data[5:0]);
                TONE1: tone1_d = ti_tone_write(tone1_q, is_latch, wr_data[5:0]);
                TONE2: tone2_d = ti_tone_write(tone2_q, is_latch, wr_data[5:0]);
                VOL0:  vol0_d  = wr_data[3:0];
                VOL1:  vol1_d  = wr_data[3:0];
                VOL2:  vol2_d  = wr_data[3:0];
                VOL3:  vol3_d  = wr_data[3:0];
                NOISE: begin
                    noise_d     = wr_data[2:0];
                    noise_rst_d = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q     <= IDLE;
            busy_cnt_q  <= '0;
            ready_q     <= 1'b1;
            latched_q   <= TONE0;
            tone0_q     <= '0;
            tone1_q     <= '0;
            tone2_q     <= '0;
            vol0_q      <= TI_VOL_SILENT;
            vol1_q      <= TI_VOL_SILENT;
            vol2_q      <= TI_VOL_SILENT;
            vol3_q      <= TI_VOL_SILENT;
            noise_q     <= '0;
            noise_rst_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            busy_cnt_q  <= busy_cnt_d;
            ready_q     <= ready_d;
            latched_q   <= latched_d;
            tone0_q     <= tone0_d;
            tone1_q     <= tone1_d;
            tone2_q     <= tone2_d;
            vol0_q      <= vol0_d;
            vol1_q      <= vol1_d;
            vol2_q      <= vol2_d;
            vol3_q      <= vol3_d;
            noise_q     <= noise_d;
            noise_rst_q <= noise_rst_d;
        end
    end

    assign wr_ready   = ready_q;
    assign tone0      = tone0_q;
    assign tone1      = tone1_q;
    assign tone2      = tone2_q;
    assign vol0       = vol0_q;
    assign vol1       = vol1_q;
    assign vol2       = vol2_q;
    assign vol3       = vol3_q;
    assign noise_ctrl = noise_q;
    assign noise_rst  = noise_rst_q;

endmodule

// File: tb/tb_ti_reg_decoder.sv
// Bench for ti_reg_decoder: directed and random writes against a register-file model,
// plus a zero-stall instance for back-to-back accepts.
module tb_ti_reg_decoder;

    logic       CLK = 1'b0;
    logic       nRST = 1'b0;
    logic       wr_valid = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       wr_ready;
    logic [9:0] tone0, tone1, tone2;
    logic [2:0] noise_ctrl;
    logic       noise_rst;
    logic [3:0] vol0, vol1, vol2, vol3;

    logic       b_valid = 1'b0;
    logic [7:0] b_data = 8'h00;
    logic       b_ready;
    logic [9:0] b_tone0, b_tone1, b_tone2;
    logic [2:0] b_noise_ctrl;
    logic       b_noise_rst;
    logic [3:0] b_vol0, b_vol1, b_vol2, b_vol3;

    int tests = 0;
    int fails = 0;

    // Reference register file
    int tone_m [3];
    int vol_m  [4];
    int noise_m;
    int latched_m;

    always #5 CLK = ~CLK;

    ti_reg_decoder #(.BUSY_CYCLES(32)) dut (
        .CLK(CLK), .nRST(nRST), .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
        .tone0(tone0), .tone1(tone1), .tone2(tone2), .noise_ctrl(noise_ctrl),
        .noise_rst(noise_rst), .vol0(vol0), .vol1(vol1), .vol2(vol2), .vol3(vol3)
    );

    ti_reg_decoder #(.BUSY_CYCLES(0)) dut0 (
        .CLK(CLK), .nRST(nRST), .wr_valid(b_valid), .wr_data(b_data), .wr_ready(b_ready),
        .tone0(b_tone0), .tone1(b_tone1), .tone2(b_tone2), .noise_ctrl(b_noise_ctrl),
        .noise_rst(b_noise_rst), .vol0(b_vol0), .vol1(b_vol1), .vol2(b_vol2), .vol3(b_vol3)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++) tone_m[i] = 0;
        for (int i = 0; i < 4; i++) vol_m[i] = 15;
        noise_m   = 0;
        latched_m = 0;
    endtask

    // Returns 1 when the byte lands on the noise register.
    function automatic bit model_write(input int b);
        int sel, ch;
        if (b >= 128) latched_m = (b >> 4) & 7;
        sel = latched_m;
        ch  = sel >> 1;
        if (sel == 6) begin
            noise_m = b & 7;
            return 1'b1;
        end
        if (sel % 2 == 1) vol_m[ch] = b & 15;
        else if (b >= 128) tone_m[ch] = (tone_m[ch] / 16) * 16 + (b & 15);
        else tone_m[ch] = (tone_m[ch] % 16) + (b & 63) * 16;
        return 1'b0;
    endfunction

    task automatic check_all(input string tag);
        check({tag, ".tone0"}, 32'(tone0), 32'(tone_m[0]));
        check({tag, ".tone1"}, 32'(tone1), 32'(tone_m[1]));
        check({tag, ".tone2"}, 32'(tone2), 32'(tone_m[2]));
        check({tag, ".vol0"}, 32'(vol0), 32'(vol_m[0]));
        check({tag, ".vol1"}, 32'(vol1), 32'(vol_m[1]));
        check({tag, ".vol2"}, 32'(vol2), 32'(vol_m[2]));
        check({tag, ".vol3"}, 32'(vol3), 32'(vol_m[3]));
        check({tag, ".noise"}, 32'(noise_ctrl), 32'(noise_m));
    endtask

    // Present a byte until accepted, then check decode, noise pulse and busy-window length.
    task automatic do_write(input logic [7:0] b, input string tag);
        logic r;
        bit   nz;
        int   n;
        int   low;
        wr_valid = 1'b1;
        wr_data  = b;
        r = 1'b0;
        n = 0;
        while (!r && n < 200) begin
            r = wr_ready;
            @(posedge CLK); #1;
            n++;
        end
        wr_valid = 1'b0;
        check({tag, ".accepted"}, 32'(r), 32'd1);
        nz = model_write(int'(b));
        check_all(tag);
        check({tag, ".noise_rst_hi"}, 32'(noise_rst), 32'(nz));
        low = 0;
        while (wr_ready === 1'b0 && low < 100) begin
            low++;
            @(posedge CLK); #1;
            if (low == 1) check({tag, ".noise_rst_lo"}, 32'(noise_rst), 32'd0);
        end
        check({tag, ".busy_len"}, 32'(low), 32'd32);
    endtask

    initial begin
        int   accepts, cyc, last;
        logic r;
        bit   nz;

        model_reset();
        repeat (3) @(posedge CLK);
        #1;
        check("reset.ready", 32'(wr_ready), 32'd1);
        check("reset.noise_rst", 32'(noise_rst), 32'd0);
        check_all("reset");
        nRST = 1'b1;
        @(posedge CLK); #1;

        // Tone latch/data pair
        do_write(8'h8E, "tone_latch");
        do_write(8'h0F, "tone_data");
        check("tone0_0FE", 32'(tone0), 32'h0FE);

        // Volume latch then data; tone1 untouched
        do_write(8'hB3, "vol_latch");
        check("vol1_3", 32'(vol1), 32'h3);
        do_write(8'h0A, "vol_data");
        check("vol1_A", 32'(vol1), 32'hA);
        check("tone1_keep", 32'(tone1), 32'h0);

        // Noise latch then data
        do_write(8'hE5, "noise_latch");
        check("noise_5", 32'(noise_ctrl), 32'h5);
        do_write(8'h03, "noise_data");
        check("noise_3", 32'(noise_ctrl), 32'h3);

        // Continuous valid: one accept every 33 cycles
        wr_valid = 1'b1;
        wr_data  = 8'h9F;
        accepts = 0; cyc = 0; last = 0;
        while (accepts < 4 && cyc < 400) begin
            r = wr_ready;
            @(posedge CLK); #1;
            cyc++;
            if (r) begin
                accepts++;
                nz = model_write(32'h9F);
                if (accepts > 1) check("stall_spacing", 32'(cyc - last), 32'd33);
                last = cyc;
            end
        end
        wr_valid = 1'b0;
        check("stall_accepts", 32'(accepts), 32'd4);
        check_all("stall");
        check("stall.vol0", 32'(vol0), 32'hF);

        // Random bytes against the model
        for (int i = 0; i < 30; i++) begin
            logic [7:0] rb;
            rb = 8'($urandom);
            do_write(rb, $sformatf("rand%0d_%02h", i, rb));
        end

        // Reset in the middle of a busy window
        do_write(8'h91, "pre_rst_vol");
        wr_valid = 1'b1;
        wr_data  = 8'hC5;
        r = 1'b0;
        cyc = 0;
        while (!r && cyc < 200) begin
            r = wr_ready;
            @(posedge CLK); #1;
            cyc++;
        end
        wr_valid = 1'b0;
        nz = model_write(32'hC5);
        repeat (10) @(posedge CLK);
        #1;
        check("midbusy.ready_low", 32'(wr_ready), 32'd0);
        nRST = 1'b0;
        #1;
        model_reset();
        check("midbusy.ready", 32'(wr_ready), 32'd1);
        check("midbusy.noise_rst", 32'(noise_rst), 32'd0);
        check_all("midbusy");
        @(negedge CLK);
        nRST = 1'b1;
        @(posedge CLK); #1;
        // After reset, a lone data byte targets tone0
        do_write(8'h15, "post_rst_data");
        check("post_rst_tone0", 32'(tone0), 32'h150);

        // Zero-stall instance: four writes in four consecutive cycles
        b_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            logic [7:0] seq [4];
            seq = '{8'h81, 8'h02, 8'hC7, 8'h3F};
            b_data = seq[i];
            check($sformatf("b2b.ready%0d", i), 32'(b_ready), 32'd1);
            @(posedge CLK); #1;
        end
        b_valid = 1'b0;
        check("b2b.tone0", 32'(b_tone0), 32'h021);
        check("b2b.tone2", 32'(b_tone2), 32'h3F7);
        check("b2b.ready_after", 32'(b_ready), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ti_reg_decoder.md
# ti_reg_decoder

CPU-side write port of the TI SN76489-compatible PSG. Accepts single-byte register writes in SN76489 latch/data format over a valid/ready handshake and decodes them into the eight PSG registers. It drives the tone and noise generators and the `vol0..vol3` attenuation inputs of `ti_mixer`. A post-write busy window models the chip's READY stall.

## Interface
Parameters:
- `BUSY_CYCLES`, default 32: number of cycles `wr_ready` stays low after an accepted write. 0 means no stall.

Ports:
- `CLK`  in  1  clock
- `nRST`  in  1  reset, asynchronous, active-low
- `wr_valid`  in  1  write byte present
- `wr_data`  in  8  write byte
- `wr_ready`  out  1  block can accept a byte
- `tone0`, `tone1`, `tone2`  out  10 each  tone period registers
- `noise_ctrl`  out  3  noise control: bit 2 = white/periodic, bits 1:0 = rate
- `noise_rst`  out  1  one-cycle pulse; resets the noise LFSR
- `vol0`, `vol1`, `vol2`, `vol3`  out  4 each  attenuation values; 4'hF = silent, 4'h0 = loudest

## Operation
- Accept: a byte is accepted on a rising edge where `wr_valid && wr_ready` holds.
- Latch byte (`wr_data[7]=1`):
  - Register select: `sel = wr_data[6:4]`, with channel in bits 6:5 and type in bit 4 (1 = volume).
  - Map: 000 tone0, 001 vol0, 010 tone1, 011 vol1, 100 tone2, 101 vol2, 110 noise, 111 vol3.
  - Stores `sel` into `latched`.
  - Writes `wr_data[3:0]` into bits 3:0 of the selected register. For tone registers, bits 9:4 are unchanged. For noise, only `wr_data[2:0]` is used.
- Data byte (`wr_data[7]=0`):
  - Targets the `latched` register.
  - Tone target: bits 9:4 of the register = `wr_data[5:0]`.
  - Volume target: register = `wr_data[3:0]`.
  - Noise target: register = `wr_data[2:0]`.
  - `wr_data[6]` is ignored. `latched` is unchanged.
- `noise_rst`: pulses for exactly one cycle after any accepted byte (latch or data) whose target is the noise register. The pulse occurs even if the value written is unchanged.
- Busy FSM:
  - States: IDLE (`wr_ready=1`) and BUSY (`wr_ready=0`), with a down-counter `busy_cnt` of width `$clog2(BUSY_CYCLES+1)`.
  - IDLE to BUSY on accept: load `busy_cnt = BUSY_CYCLES-1`.
  - In BUSY, decrement each cycle. BUSY to IDLE when `busy_cnt==0`.
  - If `BUSY_CYCLES==0`, the FSM stays in IDLE permanently and back-to-back writes are accepted every cycle.
  - `wr_valid` during BUSY is ignored. The byte is not lost by this block; the sender holds it until `wr_ready` returns.
- Reset values (asynchronous, on `nRST` low, including mid-BUSY):
  - `vol0..3` = 4'hF
  - `tone0..2` = 0
  - `noise_ctrl` = 0
  - `noise_rst` = 0
  - `latched` = 000 (tone0)
  - FSM = IDLE, `wr_ready` = 1, `busy_cnt` = 0

## Timing
- Register outputs update on the accepting edge, so they are visible in the cycle after the accept.
- `noise_rst` is high in the cycle after the accept and low one cycle later.
- `wr_ready` is low for exactly `BUSY_CYCLES` cycles starting in the cycle after the accept, then high.
- Minimum spacing between accepts is `BUSY_CYCLES+1` cycles.
- All outputs are registered; there are no combinational paths from `wr_*` inputs to outputs.
- `wr_ready` is a function of state only and does not depend on `wr_valid`.
- A data byte arriving before any latch byte targets tone0.

## Structure
- Shared package `ti_pkg` holds:
  - `typedef enum logic [2:0] ti_reg_sel_t` with values TONE0, VOL0, TONE1, VOL1, TONE2, VOL2, NOISE, VOL3 (encoding as mapped above).
  - `localparam TI_VOL_SILENT = 4'hF`.
  - `localparam TI_BUSY_DEFAULT = 32`.
- `ti_mixer` shares `ti_pkg`.
- Single module; no sub-module. The busy counter is inline.

## Test plan
- Reset: hold `nRST` low, then release. Expect `vol0..3` = F, tones = 0, `wr_ready` = 1, `noise_rst` = 0.
- Tone write pair: write 0x8E then 0x0F. Expect `tone0` = 0x0FE. After each accept, `wr_ready` is low for exactly 32 cycles.
- Volume latch and data: write 0xB3, then 0x0A. Expect `vol1` = 3, then `vol1` = 0xA, with `tone1` unchanged.
- Noise: write 0xE5, then 0x03. Expect `noise_ctrl` = 5, then 3, with one `noise_rst` pulse after each write.
- Busy stall: assert `wr_valid` with 0x9F continuously from the first accept. Expect exactly one accept per 33 cycles; bytes presented during BUSY are not accepted.
- Reset mid-BUSY: drop `nRST` 10 cycles into BUSY. Expect `wr_ready` = 1 immediately and all registers back at reset values. With `BUSY_CYCLES=0`, 4 back-to-back writes are accepted in 4 consecutive cycles.
